// File: rtl/elastic_pipe_pkg.sv
// Shared types and width defaults for the elastic pipeline register.
// State encoding doubles as the occupancy count (EMPTY=0, ONE=1, FULL=2).
package elastic_pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } state_e;

    localparam int DATA_W_DFLT = 32;
    localparam int IDX_W_DFLT  = 6;

endpackage

// File: rtl/sat_counter.sv
// 32-bit saturating up-counter with synchronous clear.
// Ports: clk, clr_i (sync clear, wins), inc_i (count enable), cnt_o (value).
module sat_counter (
    input  logic        clk,
    input  logic        clr_i,
    input  logic        inc_i,
    output logic [31:0] cnt_o
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/elastic_pipeline_register.sv
// Two-entry elastic (skid) pipeline register with flush; in_ready is registered-state only.
// Ports: clk, reset (sync, active-high), flush, in_valid/in_ready/in_data/in_idx,
// out_valid/out_ready/out_data/out_idx, occ (0..2).
// Macro ELASTIC_PIPE_STALL_CNT_EN adds stall_cnt: saturating count of out_valid & !out_ready cycles.
module elastic_pipeline_register
    import elastic_pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT,
    parameter int IDX_W  = IDX_W_DFLT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [IDX_W-1:0]  in_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic [1:0]        occ
`ifdef ELASTIC_PIPE_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [IDX_W-1:0]  main_idx_q, main_idx_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [IDX_W-1:0]  skid_idx_q, skid_idx_d;

    logic in_fire;
    logic out_fire;

    assign in_ready  = (state_q != FULL) && !reset;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_data_q;
    assign out_idx   = main_idx_q;
    assign occ       = state_q;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_idx_d  = main_idx_q;
        skid_data_d = skid_data_q;
        skid_idx_d  = skid_idx_q;

        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d     = ONE;
                    main_data_d = in_data;
                    main_idx_d  = in_idx;
                end
            end
            ONE: begin
                case ({in_fire, out_fire})
                    2'b10: begin
                        state_d     = FULL;
                        skid_data_d = in_data;
                        skid_idx_d  = in_idx;
                    end
                    2'b11: begin
                        main_data_d = in_data;
                        main_idx_d  = in_idx;
                    end
                    2'b01: state_d = EMPTY;
                    default: ;
                endcase
            end
            FULL: begin
                if (out_fire) begin
                    state_d     = ONE;
                    main_data_d = skid_data_q;
                    main_idx_d  = skid_idx_q;
                end
            end
            default: state_d = EMPTY;
        endcase

        // Flush drops occupancy only; payload registers keep their contents.
        if (flush) begin
            state_d     = EMPTY;
            main_data_d = main_data_q;
            main_idx_d  = main_idx_q;
            skid_data_d = skid_data_q;
            skid_idx_d  = skid_idx_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_idx_q  <= '0;
            skid_data_q <= '0;
            skid_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_idx_q  <= main_idx_d;
            skid_data_q <= skid_data_d;
            skid_idx_q  <= skid_idx_d;
        end
    end

`ifdef ELASTIC_PIPE_STALL_CNT_EN
    // A flushed cycle is not a stall: the presented entry is being discarded.
    logic stall_inc;
    assign stall_inc = out_valid && !out_ready && !flush;

    sat_counter u_stall_cnt (
        .clk   (clk),
        .clr_i (reset),
        .inc_i (stall_inc),
        .cnt_o (stall_cnt)
    );
`endif

endmodule

// File: tb/tb_elastic_pipeline_register.sv
// Testbench for elastic_pipeline_register: queue model plus directed literal checks.
// Build with ELASTIC_PIPE_STALL_CNT_EN defined to also check stall_cnt.
module tb_elastic_pipeline_register;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [5:0]  in_idx;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [5:0]  out_idx;
    logic [1:0]  occ;
`ifdef ELASTIC_PIPE_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    elastic_pipeline_register #(.DATA_W(32), .IDX_W(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_idx    (in_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .occ       (occ)
`ifdef ELASTIC_PIPE_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic [5:0]  i;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_stall = '0;
    int          checks = 0;
    int          errors = 0;
    bit          cmp_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: FIFO of depth 2, ready whenever not full and not in reset.
    always @(posedge clk) begin
        bit inr, inf, outf;
        inr  = (mq.size() < 2) && !reset;
        inf  = in_valid && inr;
        outf = (mq.size() > 0) && out_ready;
        if (reset) begin
            m_stall = '0;
        end else if ((mq.size() > 0) && !out_ready && !flush
                     && (m_stall != 32'hFFFF_FFFF)) begin
            m_stall = m_stall + 1;
        end
        if (reset || flush) begin
            mq.delete();
        end else begin
            if (outf) void'(mq.pop_front());
            if (inf) mq.push_back('{d: in_data, i: in_idx});
        end
        cmp_en = 1'b1;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_occ", 64'(occ), 64'(mq.size()));
            chk("m_out_valid", 64'(out_valid), 64'(mq.size() > 0));
            chk("m_in_ready", 64'(in_ready),
                64'((mq.size() < 2) && !reset));
            if (mq.size() > 0) begin
                chk("m_out_data", 64'(out_data), 64'(mq[0].d));
                chk("m_out_idx", 64'(out_idx), 64'(mq[0].i));
            end
`ifdef ELASTIC_PIPE_STALL_CNT_EN
            chk("m_stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic [5:0] i);
        in_valid = 1'b1;
        in_data  = d;
        in_idx   = i;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_idx    = '0;
        out_ready = 1'b0;

        step();
        step();
        chk("rst_occ", 64'(occ), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);

        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Single entry, one-cycle latency
        out_ready = 1'b1;
        push(32'hA5A5_0001, 6'd3);
        chk("lat_out_valid", 64'(out_valid), 64'd1);
        chk("lat_out_data", 64'(out_data), 64'hA5A5_0001);
        chk("lat_out_idx", 64'(out_idx), 64'd3);
        chk("lat_occ", 64'(occ), 64'd1);
        step();

        // Fill to FULL under backpressure, then drain in order
        out_ready = 1'b0;
        push(32'h11, 6'd1);
        push(32'h22, 6'd2);
        chk("full_occ", 64'(occ), 64'd2);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_out_data", 64'(out_data), 64'h11);
        out_ready = 1'b1;
        step();
        chk("drain1_data", 64'(out_data), 64'h22);
        chk("drain1_occ", 64'(occ), 64'd1);
        step();
        chk("drain2_occ", 64'(occ), 64'd0);

        // Streaming at full rate
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1;
            in_data  = 32'(k);
            in_idx   = 6'(k);
            step();
            chk("stream_data", 64'(out_data), 64'(k));
            chk("stream_occ", 64'(occ), 64'd1);
            chk("stream_in_ready", 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        step();

        // Flush while FULL with a simultaneous offer
        out_ready = 1'b0;
        push(32'h44, 6'd4);
        push(32'h55, 6'd5);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h33;
        in_idx   = 6'd33;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_occ", 64'(occ), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_data_kept", 64'(out_data), 64'h44);
        out_ready = 1'b1;
        repeat (3) step();

        // Mixed valid/ready pattern with occasional flush
        for (int k = 0; k < 48; k++) begin
            in_valid  = (k % 3) != 1;
            out_ready = (k % 4) != 2;
            flush     = (k == 20) || (k == 37);
            in_data   = 32'h1000 + 32'(k);
            in_idx    = 6'(k);
            step();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();

        // Stall counting across a flush, cleared by reset
        reset = 1'b1;
        step();
        reset     = 1'b0;
        out_ready = 1'b0;
        push(32'h66, 6'd6);
        repeat (7) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
`ifdef ELASTIC_PIPE_STALL_CNT_EN
        chk("stall_after_flush", 64'(stall_cnt), 64'd7);
`endif
        step();
`ifdef ELASTIC_PIPE_STALL_CNT_EN
        chk("stall_held", 64'(stall_cnt), 64'd7);
`endif
        reset = 1'b1;
        step();
        reset = 1'b0;
`ifdef ELASTIC_PIPE_STALL_CNT_EN
        chk("stall_reset", 64'(stall_cnt), 64'd0);
`endif

        // Reset while FULL
        push(32'h77, 6'd7);
        push(32'h88, 6'd8);
        chk("pre_rst_occ", 64'(occ), 64'd2);
        reset = 1'b1;
        step();
        chk("midrst_occ", 64'(occ), 64'd0);
        chk("midrst_out_data", 64'(out_data), 64'd0);
        chk("midrst_out_idx", 64'(out_idx), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        reset = 1'b0;
        #1;
        chk("midrst_release_in_ready", 64'(in_ready), 64'd1);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
